// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: opcodes, instruction field offsets and FSM encoding shared by the issue controller
package alu_issue_ctrl_pkg;
    localparam int DATA_WIDTH = 4;
    localparam int NUM_REG    = 4;
    localparam int ADDR_WIDTH = 2;
    localparam int RT_LSB     = 0;
    localparam int RS_LSB     = ADDR_WIDTH;
    localparam int RD_LSB     = 2 * ADDR_WIDTH;
    localparam int OP_LSB     = 3 * ADDR_WIDTH;
    localparam int INSTR_W    = OP_LSB + 3;
    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        INC  = 3'd2,
        NOR  = 3'd3,
        NAND = 3'd4,
        SHR2 = 3'd5,
        SHL1 = 3'd6,
        MUL  = 3'd7
    } op_e;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_e;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, preload, ALU and writeback bus of the issue controller
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3+3*ADDR_W-1:0] in_instr;
    logic                  load_en;
    logic [ADDR_W-1:0]     load_addr;
    logic [DATA_W-1:0]     load_data;
    logic [2:0]            op_code;
    logic [DATA_W-1:0]     rs;
    logic [DATA_W-1:0]     rt;
    logic [DATA_W-1:0]     alu_rd;
    logic                  wb_valid;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic [ADDR_W-1:0]     dbg_addr;
    logic [DATA_W-1:0]     dbg_data;
    logic [7:0]            instr_cnt;
    modport slave (
        input  in_valid, in_instr, load_en, load_addr, load_data, alu_rd, dbg_addr,
        output in_ready, op_code, rs, rt, wb_valid, wb_addr, wb_data, dbg_data, instr_cnt
    );
    modport master (
        output in_valid, in_instr, load_en, load_addr, load_data, alu_rd, dbg_addr,
        input  in_ready, op_code, rs, rt, wb_valid, wb_addr, wb_data, dbg_data, instr_cnt
    );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// alu_regfile: NREG x DATA_W storage, one write port and three combinational read ports
module alu_regfile #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] mem [NREG];
    // single write port, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rs_data  = mem[rs_addr];
    assign rt_data  = mem[rt_addr];
    assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences IDLE/ISSUE/WB to run instructions through the external ALU into a local register file
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int NREG   = NUM_REG,
    parameter int ADDR_W = ADDR_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    alu_issue_ctrl_if.slave bus
);
    state_e                state, nxt;
    logic [3+3*ADDR_W-1:0] ir;
    logic [DATA_W-1:0]     res_q, rf_rs, rf_rt, rf_wdata;
    logic [ADDR_W-1:0]     rf_waddr, rd_a;
    logic                  rf_we;
    logic [7:0]            cnt;
    assign rd_a          = ir[RD_LSB +: ADDR_W];
    assign bus.instr_cnt = cnt;
    alu_regfile #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .rs_addr  (ir[RS_LSB +: ADDR_W]),
        .rt_addr  (ir[RT_LSB +: ADDR_W]),
        .dbg_addr (bus.dbg_addr),
        .rs_data  (rf_rs),
        .rt_data  (rf_rt),
        .dbg_data (bus.dbg_data)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    // accept in IDLE, then one ISSUE and one WB cycle
    always_comb begin
        nxt = state == IDLE  ? (bus.in_valid ? ISSUE : IDLE) :
              state == ISSUE ? WB : IDLE;
    end
    // ALU drive, writeback strobe and register-file write mux (WB wins; preload only in IDLE)
    always_comb begin
        bus.in_ready = state == IDLE;
        bus.op_code  = state == ISSUE ? ir[OP_LSB +: 3] : 3'd0;
        bus.rs       = state == ISSUE ? rf_rs : '0;
        bus.rt       = state == ISSUE ? rf_rt : '0;
        bus.wb_valid = state == WB;
        bus.wb_addr  = state == WB ? rd_a : '0;
        bus.wb_data  = state == WB ? res_q : '0;
        rf_we        = state == WB || (state == IDLE && bus.load_en);
        rf_waddr     = state == WB ? rd_a : bus.load_addr;
        rf_wdata     = state == WB ? res_q : bus.load_data;
    end
    // instruction latch, result capture and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= '0;
            res_q <= '0;
            cnt   <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) ir <= bus.in_instr;
            if (state == ISSUE) res_q <= bus.alu_rd;
            if (state == WB) cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed tests plus a cycle-by-cycle reference model of the issue controller
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;
    logic clk = 0;
    logic rst_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    alu_issue_ctrl_if #(.DATA_W(4), .ADDR_W(2)) bus ();
    alu_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
        case (op)
            3'd0: return 4'(a + b);
            3'd1: return 4'(a - b);
            3'd2: return 4'(a + 4'd1);
            3'd3: return ~(a | b);
            3'd4: return ~(a & b);
            3'd5: return a >> 2;
            3'd6: return 4'(a << 1);
            default: return p[3:0];
        endcase
    endfunction

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        return {op, rd, rs, rt};
    endfunction

    assign bus.alu_rd = alu_f(bus.op_code, bus.rs, bus.rt);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: the result is fixed at accept time from the (post-preload) register contents
    logic [3:0] m_rf [4];
    int         m_busy;
    logic [1:0] m_rd;
    logic [2:0] m_op;
    logic [3:0] m_a, m_b, m_res;
    logic [7:0] m_cnt;

    function automatic logic [3:0] pre(input logic [1:0] a);
        return (bus.load_en && bus.load_addr == a) ? bus.load_data : m_rf[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_rf[i] <= '0;
            m_busy <= 0;
            m_cnt  <= '0;
            m_rd   <= '0;
            m_op   <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_res  <= '0;
        end else if (m_busy == 0) begin
            if (bus.load_en) m_rf[bus.load_addr] <= bus.load_data;
            if (bus.in_valid) begin
                m_busy <= 2;
                m_op   <= bus.in_instr[8:6];
                m_rd   <= bus.in_instr[5:4];
                m_a    <= pre(bus.in_instr[3:2]);
                m_b    <= pre(bus.in_instr[1:0]);
                m_res  <= alu_f(bus.in_instr[8:6], pre(bus.in_instr[3:2]), pre(bus.in_instr[1:0]));
            end
        end else if (m_busy == 2) begin
            m_busy <= 1;
        end else begin
            m_rf[m_rd] <= m_res;
            m_cnt      <= m_cnt + 8'd1;
            m_busy     <= 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, m_busy == 0);
        chk("op_code", bus.op_code, m_busy == 2 ? m_op : 3'd0);
        chk("rs", bus.rs, m_busy == 2 ? m_a : 4'd0);
        chk("rt", bus.rt, m_busy == 2 ? m_b : 4'd0);
        chk("wb_valid", bus.wb_valid, m_busy == 1);
        chk("wb_addr", bus.wb_addr, m_busy == 1 ? m_rd : 2'd0);
        chk("wb_data", bus.wb_data, m_busy == 1 ? m_res : 4'd0);
        chk("dbg_data", bus.dbg_data, m_rf[bus.dbg_addr]);
        chk("instr_cnt", bus.instr_cnt, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_dbg(input logic [1:0] a, input logic [3:0] exp, input string nm);
        bus.dbg_addr = a;
        @(negedge clk);
        chk(nm, bus.dbg_data, exp);
        tick();
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        bus.load_en   = 1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_en = 0;
    endtask

    task automatic issue(input logic [8:0] ins, input logic [3:0] exp, input string nm);
        bus.in_valid = 1;
        bus.in_instr = ins;
        tick();
        bus.in_valid = 0;
        chk({nm, "_issue_ready"}, bus.in_ready, 0);
        chk({nm, "_issue_wb"}, bus.wb_valid, 0);
        chk({nm, "_issue_op"}, bus.op_code, ins[8:6]);
        tick();
        chk({nm, "_wb_valid"}, bus.wb_valid, 1);
        chk({nm, "_wb_addr"}, bus.wb_addr, ins[5:4]);
        chk({nm, "_wb_data"}, bus.wb_data, exp);
        tick();
        chk({nm, "_idle_wb"}, bus.wb_valid, 0);
        rd_dbg(ins[5:4], exp, {nm, "_dbg"});
    endtask

    task automatic issue_q(input logic [8:0] ins);
        bus.in_valid = 1;
        bus.in_instr = ins;
        tick();
        bus.in_valid = 0;
        tick();
        tick();
    endtask

    initial begin
        int acc;
        bus.in_valid  = 0;
        bus.in_instr  = '0;
        bus.load_en   = 0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.dbg_addr  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int a = 0; a < 4; a++) rd_dbg(2'(a), 4'd0, "reset_rf");
        chk("reset_ready", bus.in_ready, 1);
        chk("reset_cnt", bus.instr_cnt, 0);
        chk("reset_op", bus.op_code, 0);
        chk("reset_rs", bus.rs, 0);
        chk("reset_rt", bus.rt, 0);
        load(1, 4'd3); load(2, 4'd5);
        issue(mk(ADD, 0, 1, 2), 4'd8, "add");
        chk("cnt_after_add", bus.instr_cnt, 1);
        load(1, 4'd2);
        issue(mk(SUB, 3, 1, 2), 4'hD, "sub");
        load(1, 4'd15);
        issue(mk(INC, 0, 1, 0), 4'd0, "inc_wrap");
        load(1, 4'b0101); load(2, 4'b0011);
        issue(mk(NOR, 0, 1, 2), 4'b1000, "nor");
        issue(mk(NAND, 0, 1, 2), 4'b1110, "nand");
        load(1, 4'b1100);
        issue(mk(SHR2, 0, 1, 0), 4'b0011, "shr2");
        load(1, 4'b0111);
        issue(mk(SHL1, 0, 1, 0), 4'b1110, "shl1");
        load(2, 4'd3);
        issue(mk(MUL, 0, 1, 2), 4'd5, "mul_7x3");
        load(1, 4'd3); load(2, 4'd5);
        issue(mk(MUL, 0, 1, 2), 4'd15, "mul_3x5");
        load(1, 4'd0);
        acc = 0;
        bus.in_valid = 1;
        bus.in_instr = mk(INC, 1, 1, 1);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("chain_ready", bus.in_ready, (i % 3) == 0);
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 0;
        chk("chain_accepts", acc, 6);
        rd_dbg(1, 4'd6, "chain_r1");
        load(2, 4'd4);
        bus.in_valid = 1;
        bus.in_instr = mk(ADD, 3, 2, 2);
        tick();
        bus.in_valid  = 0;
        bus.load_en   = 1;
        bus.load_addr = 2;
        bus.load_data = 4'd9;
        tick();
        bus.load_en = 0;
        tick();
        rd_dbg(2, 4'd4, "load_in_issue_r2");
        rd_dbg(3, 4'd8, "load_in_issue_r3");
        bus.load_en   = 1;
        bus.load_addr = 1;
        bus.load_data = 4'd4;
        bus.in_valid  = 1;
        bus.in_instr  = mk(INC, 0, 1, 1);
        tick();
        bus.load_en  = 0;
        bus.in_valid = 0;
        tick();
        tick();
        rd_dbg(0, 4'd5, "load_accept_r0");
        rd_dbg(1, 4'd4, "load_accept_r1");
        rst_n = 0;
        tick();
        rst_n = 1;
        load(1, 4'd7);
        bus.in_valid = 1;
        bus.in_instr = mk(INC, 2, 1, 1);
        tick();
        bus.in_valid = 0;
        tick();
        chk("abort_wb_before", bus.wb_valid, 1);
        rst_n = 0;
        #1;
        chk("abort_wb_valid", bus.wb_valid, 0);
        chk("abort_cnt", bus.instr_cnt, 0);
        tick();
        rst_n = 1;
        tick();
        rd_dbg(2, 4'd0, "abort_r2");
        chk("abort_cnt_after", bus.instr_cnt, 0);
        for (int i = 0; i < 256; i++) begin
            issue_q(mk(ADD, 0, 0, 0));
            if (i == 254) chk("cnt_255", bus.instr_cnt, 255);
        end
        chk("cnt_wrap", bus.instr_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
